// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared constants and action decode type for the EX/MEM pipeline register
package ex_mem_stage_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALUOP_W    = 8;
  localparam int DEF_STALL_W    = 6;

  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } stage_act_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - per-instruction payload bus between pipeline stages
interface ex_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8
);
  logic [REG_ADDR_W-1:0] wd;
  logic                  wreg;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     hi;
  logic [DATA_W-1:0]     lo;
  logic                  whilo;
  logic [ALUOP_W-1:0]    aluop;
  logic [DATA_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     reg2;

  modport master (output wd, wreg, wdata, hi, lo, whilo, aluop, mem_addr, reg2);
  modport slave  (input  wd, wreg, wdata, hi, lo, whilo, aluop, mem_addr, reg2);
endinterface

// File: rtl/ex_mem_stage_sat_counter.sv
// rtl/ex_mem_stage_sat_counter.sv - saturating up-counter for stage performance events
module ex_mem_stage_sat_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with stall/flush handling,
// multi-cycle accumulate feedback and a bubble counter
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALUOP_W    = DEF_ALUOP_W,
  parameter int STALL_W    = DEF_STALL_W,
  parameter int STAGE      = STAGE_EX,
  parameter int CNT_W      = 2,
  parameter int PERF_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  ex_mem_stage_if.slave       ex,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [CNT_W-1:0]    ex_cnt,
  ex_mem_stage_if.master      mem,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  stage_act_e act;

  // Stall bits belonging to other stages do not affect this register.
  logic unused_stall;
  assign unused_stall = ^stall;

  always_comb begin
    act = ACT_ADVANCE;
    if (rst)                                 act = ACT_RESET;
    else if (flush)                          act = ACT_FLUSH;
    else if (stall[STAGE] && !stall[STAGE+1]) act = ACT_BUBBLE;
    else if (stall[STAGE])                   act = ACT_HOLD;
  end

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        mem.wd       <= REG_ADDR_W'(NOPRegAddr);
        mem.wreg     <= WriteDisable;
        mem.wdata    <= DATA_W'(ZeroWord);
        mem.hi       <= DATA_W'(ZeroWord);
        mem.lo       <= DATA_W'(ZeroWord);
        mem.whilo    <= WriteDisable;
        mem.aluop    <= {ALUOP_W{1'b0}};
        mem.mem_addr <= DATA_W'(ZeroWord);
        mem.reg2     <= DATA_W'(ZeroWord);
        mem_valid    <= 1'b0;
        // A bubble is EX asking for a second cycle, so its partial state survives.
        if (act == ACT_BUBBLE) begin
          hilo_temp_o <= ex_hilo_temp;
          cnt_o       <= ex_cnt;
        end else begin
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
      end
      ACT_ADVANCE: begin
        mem.wd       <= ex.wd;
        mem.wreg     <= ex.wreg;
        mem.wdata    <= ex.wdata;
        mem.hi       <= ex.hi;
        mem.lo       <= ex.lo;
        mem.whilo    <= ex.whilo;
        mem.aluop    <= ex.aluop;
        mem.mem_addr <= ex.mem_addr;
        mem.reg2     <= ex.reg2;
        mem_valid    <= 1'b1;
        hilo_temp_o  <= '0;
        cnt_o        <= '0;
      end
      default: ;
    endcase
  end

  ex_mem_stage_sat_counter #(
    .PERF_W (PERF_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (act == ACT_BUBBLE),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int OP_W   = 8;
  localparam int ST_W   = 6;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ST_W-1:0]   stall;
  logic              flush;
  logic [63:0]       ex_hilo_temp;
  logic [CNT_W-1:0]  ex_cnt;
  logic              mem_valid;
  logic [63:0]       hilo_temp_o;
  logic [CNT_W-1:0]  cnt_o;
  logic [PERF_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  ex_mem_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ALUOP_W(OP_W)) ex_bus ();
  ex_mem_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ALUOP_W(OP_W)) mem_bus ();

  ex_mem_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ALUOP_W(OP_W), .STALL_W(ST_W),
    .STAGE(3), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex           (ex_bus),
    .ex_hilo_temp (ex_hilo_temp),
    .ex_cnt       (ex_cnt),
    .mem          (mem_bus),
    .mem_valid    (mem_valid),
    .hilo_temp_o  (hilo_temp_o),
    .cnt_o        (cnt_o),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                        input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2);
    ex_bus.wd = wd; ex_bus.wreg = wreg; ex_bus.wdata = wdata; ex_bus.hi = hi; ex_bus.lo = lo;
    ex_bus.whilo = whilo; ex_bus.aluop = aluop; ex_bus.mem_addr = addr; ex_bus.reg2 = reg2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = '0;
    set_ex(5'd3, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 8'h23, 32'h40, 32'h50);
    ex_hilo_temp = 64'hFFFF_0000_FFFF_0000; ex_cnt = 2'd2;
    step(); step();
    checks++;
    if ({mem_bus.wd, mem_bus.wreg, mem_bus.wdata, mem_bus.hi, mem_bus.lo, mem_bus.whilo,
         mem_bus.aluop, mem_bus.mem_addr, mem_bus.reg2} !== '0) begin
      errors++; $display("FAIL reset_payload got wdata=%h wreg=%b wd=%h want all zero",
                         mem_bus.wdata, mem_bus.wreg, mem_bus.wd);
    end
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mem_valid); end
    checks++;
    if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0) begin
      errors++; $display("FAIL reset_temp got %h/%0d want 0/0", hilo_temp_o, cnt_o);
    end
    checks++;
    if (bubble_cnt !== 4'h0) begin errors++; $display("FAIL reset_bubble got %h want 0", bubble_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_advance();
    stall = 6'b000000;
    set_ex(5'd7, 1'b1, 32'h1234_5678, 32'hA, 32'hB, 1'b1, 8'h9C, 32'h0000_1000, 32'hCAFE_0001);
    step();
    checks++;
    if (mem_bus.wd !== 5'd7 || mem_bus.wreg !== 1'b1 || mem_bus.wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL advance_gpr got wd=%0d wreg=%b wdata=%h want 7 1 12345678",
                         mem_bus.wd, mem_bus.wreg, mem_bus.wdata);
    end
    checks++;
    if (mem_bus.hi !== 32'hA || mem_bus.lo !== 32'hB || mem_bus.whilo !== 1'b1) begin
      errors++; $display("FAIL advance_hilo got hi=%h lo=%h whilo=%b want a b 1",
                         mem_bus.hi, mem_bus.lo, mem_bus.whilo);
    end
    checks++;
    if (mem_bus.aluop !== 8'h9C || mem_bus.mem_addr !== 32'h0000_1000 || mem_bus.reg2 !== 32'hCAFE_0001) begin
      errors++; $display("FAIL advance_ls got aluop=%h addr=%h reg2=%h want 9c 00001000 cafe0001",
                         mem_bus.aluop, mem_bus.mem_addr, mem_bus.reg2);
    end
    checks++;
    if (mem_valid !== 1'b1) begin errors++; $display("FAIL advance_valid got %b want 1", mem_valid); end
    // Outputs are registered: an input change without a clock edge must not show.
    ex_bus.wdata = 32'h0BAD_0BAD;
    #2;
    checks++;
    if (mem_bus.wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL no_comb_path got %h want 12345678", mem_bus.wdata);
    end
  endtask

  task automatic test_hold();
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(i + 20), 1'b0, 32'h5555_0000 + 32'(i), 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0);
      ex_hilo_temp = 64'h1234; ex_cnt = 2'd3;
      step();
      checks++;
      if (mem_bus.wd !== 5'd7 || mem_bus.wdata !== 32'h1234_5678 || mem_bus.wreg !== 1'b1 ||
          mem_valid !== 1'b1 || hilo_temp_o !== 64'h0 || bubble_cnt !== 4'h0) begin
        errors++; $display("FAIL hold_cycle%0d got wd=%0d wdata=%h valid=%b temp=%h bub=%h want 7 12345678 1 0 0",
                           i, mem_bus.wd, mem_bus.wdata, mem_valid, hilo_temp_o, bubble_cnt);
      end
    end
  endtask

  task automatic test_bubble_multicycle();
    stall = 6'b001000;
    set_ex(5'd9, 1'b1, 32'h7777_7777, 32'h3, 32'h4, 1'b1, 8'h18, 32'h0, 32'h0);
    ex_hilo_temp = 64'h0000_0001_0000_0002; ex_cnt = 2'd1;
    step();
    checks++;
    if (mem_bus.wreg !== 1'b0 || mem_valid !== 1'b0 || mem_bus.wdata !== 32'h0 || mem_bus.whilo !== 1'b0) begin
      errors++; $display("FAIL bubble_clear got wreg=%b valid=%b wdata=%h whilo=%b want 0 0 0 0",
                         mem_bus.wreg, mem_valid, mem_bus.wdata, mem_bus.whilo);
    end
    checks++;
    if (hilo_temp_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
      errors++; $display("FAIL bubble_temp got %h/%0d want 0000000100000002/1", hilo_temp_o, cnt_o);
    end
    checks++;
    if (bubble_cnt !== 4'h1) begin errors++; $display("FAIL bubble_count got %h want 1", bubble_cnt); end
    stall = 6'b000000;
    set_ex(5'd9, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0004, 1'b1, 8'h18, 32'h0, 32'h0);
    step();
    checks++;
    if (mem_bus.hi !== 32'h1 || mem_bus.lo !== 32'h4 || mem_bus.whilo !== 1'b1 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL multi_result got hi=%h lo=%h whilo=%b valid=%b want 1 4 1 1",
                         mem_bus.hi, mem_bus.lo, mem_bus.whilo, mem_valid);
    end
    checks++;
    if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0 || bubble_cnt !== 4'h1) begin
      errors++; $display("FAIL multi_release got temp=%h cnt=%0d bub=%h want 0 0 1", hilo_temp_o, cnt_o, bubble_cnt);
    end
  endtask

  task automatic test_stall_decode();
    // NOP with both write enables low is still valid; stall bits of other stages ignored.
    stall = 6'b110111;
    set_ex(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0);
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_bus.wreg !== 1'b0 || bubble_cnt !== 4'h1) begin
      errors++; $display("FAIL nop_advance got valid=%b wreg=%b bub=%h want 1 0 1", mem_valid, mem_bus.wreg, bubble_cnt);
    end
    stall = 6'b010000;
    set_ex(5'd12, 1'b1, 32'hABCD_0012, 32'h0, 32'h0, 1'b0, 8'h21, 32'h0, 32'h0);
    step();
    checks++;
    if (mem_bus.wd !== 5'd12 || mem_bus.wdata !== 32'hABCD_0012 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL mem_only_stall got wd=%0d wdata=%h valid=%b want 12 abcd0012 1",
                         mem_bus.wd, mem_bus.wdata, mem_valid);
    end
  endtask

  task automatic test_flush();
    stall = 6'b001000; ex_hilo_temp = 64'hAAAA_BBBB_CCCC_DDDD; ex_cnt = 2'd2;
    step();
    checks++;
    if (hilo_temp_o !== 64'hAAAA_BBBB_CCCC_DDDD || bubble_cnt !== 4'h2) begin
      errors++; $display("FAIL flush_setup got temp=%h bub=%h want aaaabbbbccccdddd 2", hilo_temp_o, bubble_cnt);
    end
    flush = 1'b1;
    set_ex(5'd15, 1'b1, 32'h1111_2222, 32'h3, 32'h4, 1'b1, 8'h55, 32'h6, 32'h7);
    step();
    checks++;
    if ({mem_bus.wd, mem_bus.wreg, mem_bus.wdata, mem_bus.hi, mem_bus.lo, mem_bus.whilo,
         mem_bus.aluop, mem_bus.mem_addr, mem_bus.reg2, mem_valid} !== '0) begin
      errors++; $display("FAIL flush_payload got wd=%0d wdata=%h valid=%b want 0 0 0", mem_bus.wd, mem_bus.wdata, mem_valid);
    end
    checks++;
    if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0 || bubble_cnt !== 4'h2) begin
      errors++; $display("FAIL flush_temp got temp=%h cnt=%0d bub=%h want 0 0 2", hilo_temp_o, cnt_o, bubble_cnt);
    end
    // Reset beats flush and clears the bubble counter.
    rst = 1'b1;
    step();
    checks++;
    if (bubble_cnt !== 4'h0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL rst_over_flush got bub=%h valid=%b want 0 0", bubble_cnt, mem_valid);
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturation();
    stall = 6'b001000;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        checks++;
        if (bubble_cnt !== 4'hE) begin errors++; $display("FAIL sat_pre got %h want e", bubble_cnt); end
      end
    end
    checks++;
    if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %h want f", bubble_cnt); end
    stall = 6'b011000;
    step();
    checks++;
    if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_after_hold got %h want f", bubble_cnt); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    set_ex(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0, 32'h0);
    ex_hilo_temp = '0; ex_cnt = '0;
    test_reset();
    test_advance();
    test_hold();
    test_bubble_multicycle();
    test_stall_decode();
    test_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
